// File: rtl/corner_pkg.sv
// rtl/corner_pkg.sv - shared types and constants for the corner capture writer
package corner_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int COUNT_W              = 17;
  localparam int DEFAULT_CORNER_DEPTH = 512;

  // Beat counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/valid_pipe.sv
// rtl/valid_pipe.sv - delays the frame BRAM address-valid strobe to line up with douta
module valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic valid_i,
  output logic valid_o
);

  logic [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else if (flush_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= DEPTH'({pipe_q, valid_i});
    end
  end

  assign valid_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/corner_capture_writer.sv
// rtl/corner_capture_writer.sv - packs the corner pixel stream into the corner BRAM
module corner_capture_writer
  import corner_pkg::*;
#(
  parameter int PIXEL_WIDTH  = 16,
  parameter int CORNER_DEPTH = DEFAULT_CORNER_DEPTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            start_flag,
  input  logic [7:0]                      corner_width,
  input  logic [8:0]                      corner_height,
  input  logic                            pixel_valid_in,
  input  logic [PIXEL_WIDTH-1:0]          pixel_data_in,
  output logic                            wr_en_out,
  output logic [$clog2(CORNER_DEPTH)-1:0] wr_addr_out,
  output logic [PIXEL_WIDTH-1:0]          wr_data_out,
  output logic                            busy_out,
  output logic                            done_out,
  output logic                            overflow_out,
  output logic [COUNT_W-1:0]              pixel_count_out
);

  localparam int ADDR_W = $clog2(CORNER_DEPTH);
  // One extra code so the pointer can sit at CORNER_DEPTH without wrapping.
  localparam int PTR_W = $clog2(CORNER_DEPTH + 1);
  localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(CORNER_DEPTH);

  state_e                 state_q, state_d;
  logic [7:0]             width_q;
  logic [8:0]             height_q;
  logic [COUNT_W-1:0]     expected_q;
  logic [COUNT_W-1:0]     count_q;
  logic [PTR_W-1:0]       addr_q;
  logic                   overflow_q;
  logic                   wr_en_q;
  logic [ADDR_W-1:0]      wr_addr_q;
  logic [PIXEL_WIDTH-1:0] wr_data_q;
  logic                   beat_valid;
  logic                   beat;

  valid_pipe #(.DEPTH(READ_LATENCY)) u_valid_pipe (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .flush_i (state_q == ARM),
    .valid_i (pixel_valid_in),
    .valid_o (beat_valid)
  );

  // A restart request wins over a beat landing on the same edge.
  assign beat = beat_valid && (state_q == CAPTURE) && (count_q != expected_q) && !start_flag;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      ARM:     state_d = (width_q == 8'd0 || height_q == 9'd0) ? DONE : CAPTURE;
      CAPTURE: if (count_q == expected_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start_flag) state_d = ARM;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      width_q    <= '0;
      height_q   <= '0;
      expected_q <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      overflow_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= 1'b0;
      if (start_flag) begin
        width_q  <= corner_width;
        height_q <= corner_height;
      end
      if (state_q == ARM) begin
        expected_q <= COUNT_W'(width_q) * COUNT_W'(height_q);
        count_q    <= '0;
        addr_q     <= '0;
        overflow_q <= 1'b0;
      end else if (beat) begin
        count_q <= sat_inc(count_q);
        if (addr_q < DEPTH_PTR) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= addr_q[ADDR_W-1:0];
          wr_data_q <= pixel_data_in;
          addr_q    <= addr_q + PTR_W'(1);
        end else begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  assign wr_en_out       = wr_en_q;
  assign wr_addr_out     = wr_addr_q;
  assign wr_data_out     = wr_data_q;
  assign busy_out        = (state_q == CAPTURE);
  assign done_out        = (state_q == DONE);
  assign overflow_out    = overflow_q;
  assign pixel_count_out = count_q;

endmodule
